clk_rate_scheduler: RTL

// - Shares one programmable clock divider between NUM_REQ requesters (display blink, animation, debounce, etc.).
// - Each requester asks for the divider with a half-period delay value. One grant is issued, and the output clock follows the owner's rate.
// - Ownership and rate changes take effect only at half-period boundaries, so clk_signal never has a runt pulse.
// - When no one owns the divider, it free-runs at DEFAULT_DELAY.

---
 rtl/clk_sched_pkg.sv | 20 ++
 rtl/rate_divider.sv | 56 +++++
 rtl/clk_rate_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/clk_sched_pkg.sv
// Shared constants, FSM encoding and the fixed-priority picker for the
// shared clock-divider scheduler.
package clk_sched_pkg;

    localparam int                    CS_DELAY_W       = 32;
    localparam logic [CS_DELAY_W-1:0] CS_DEFAULT_DELAY = 32'd49_999_999;
    localparam int                    CS_MAX_REQ       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_HANDOFF = 2'd2
    } sched_state_e;

    // Isolates the lowest set bit: index 0 has the highest priority.
    function automatic logic [CS_MAX_REQ-1:0] pick_lowest(input logic [CS_MAX_REQ-1:0] v);
        return v & (~v + CS_MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Half-period counter with a >= compare; the delay for the next half-period
// is loaded from next_delay only on a boundary cycle.
module rate_divider
    import clk_sched_pkg::*;
#(
    parameter int                 DELAY_W       = CS_DELAY_W,
    parameter logic [DELAY_W-1:0] DEFAULT_DELAY = CS_DEFAULT_DELAY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DELAY_W-1:0] next_delay,
    output logic               boundary,
    output logic               clk_signal,
    output logic               tick,
    output logic [DELAY_W-1:0] active_delay
);

    logic [DELAY_W-1:0] counter_q, counter_d;
    logic [DELAY_W-1:0] active_delay_q, active_delay_d;
    logic               clk_signal_q, clk_signal_d;
    logic               tick_q, tick_d;

    // >= rather than == so a counter already past the delay ends the half-period at once.
    always_comb begin
        boundary       = (counter_q >= active_delay_q);
        counter_d      = counter_q + DELAY_W'(1);
        clk_signal_d   = clk_signal_q;
        tick_d         = 1'b0;
        active_delay_d = active_delay_q;
        if (boundary) begin
            counter_d      = '0;
            clk_signal_d   = ~clk_signal_q;
            tick_d         = 1'b1;
            active_delay_d = next_delay;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q      <= '0;
            active_delay_q <= DEFAULT_DELAY;
            clk_signal_q   <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            active_delay_q <= active_delay_d;
            clk_signal_q   <= clk_signal_d;
            tick_q         <= tick_d;
        end
    end

    assign clk_signal   = clk_signal_q;
    assign tick         = tick_q;
    assign active_delay = active_delay_q;

endmodule

// File: rtl/clk_rate_scheduler.sv
// Shares one programmable divider between NUM_REQ requesters; ownership and
// rate only change on half-period boundaries so clk_signal never runts.
module clk_rate_scheduler
    import clk_sched_pkg::*;
#(
    parameter int                 NUM_REQ       = 4,
    parameter int                 DELAY_W       = CS_DELAY_W,
    parameter logic [DELAY_W-1:0] DEFAULT_DELAY = CS_DEFAULT_DELAY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       clk_signal,
    output logic                       tick,
    output logic [DELAY_W-1:0]         active_delay,
    output logic [1:0]                 state_dbg
);

    sched_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   pick;
    logic [CS_MAX_REQ-1:0] cand_ext;
    logic [DELAY_W-1:0]   next_delay;
    logic                 boundary;
    logic                 owner_req;

    function automatic logic [DELAY_W-1:0] slice_for(
        input logic [NUM_REQ-1:0]         sel,
        input logic [NUM_REQ*DELAY_W-1:0] dl
    );
        logic [DELAY_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) d = dl[i*DELAY_W +: DELAY_W];
        end
        return d;
    endfunction

    // Candidates exclude the current owner, so in IDLE this is simply all requesters.
    always_comb begin
        cand_ext              = '0;
        cand_ext[NUM_REQ-1:0] = req & ~grant_q;
        pick                  = NUM_REQ'(pick_lowest(cand_ext));
        owner_req             = |(req & grant_q);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        next_delay = DEFAULT_DELAY;
        if (boundary) begin
            if (owner_req) begin
                state_d    = ST_OWNED;
                next_delay = slice_for(grant_q, req_delay);
            end else if (|pick) begin
                state_d    = ST_OWNED;
                grant_d    = pick;
                next_delay = slice_for(pick, req_delay);
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end else begin
            case (state_q)
                ST_OWNED:   if (!owner_req) state_d = ST_HANDOFF;
                ST_HANDOFF: if (owner_req)  state_d = ST_OWNED;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    rate_divider #(
        .DELAY_W      (DELAY_W),
        .DEFAULT_DELAY(DEFAULT_DELAY)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .next_delay  (next_delay),
        .boundary    (boundary),
        .clk_signal  (clk_signal),
        .tick        (tick),
        .active_delay(active_delay)
    );

    assign grant     = grant_q;
    assign state_dbg = state_q;

endmodule
